// File: rtl/wb_write_queue.sv
// Posted-write queue in front of a register-file write port: requests are
// buffered in a small FIFO, drained one per cycle, and pending values are bypassed to readers.
module wb_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_data,
    input  logic        flush,
    output logic [4:0]  A3,
    output logic [31:0] WD3,
    output logic        WE3,
    input  logic [4:0]  rd_addr1,
    input  logic [4:0]  rd_addr2,
    output logic        byp_hit1,
    output logic        byp_hit2,
    output logic [31:0] byp_data1,
    output logic [31:0] byp_data2,
    output logic [31:0] busy,
    output logic [3:0]  count
);

    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [4:0]    addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [3:0]    count_q, count_d;
    logic [4:0]    a3_q, a3_d;
    logic [31:0]   wd3_q, wd3_d;
    logic          we3_q, we3_d;
    logic          push;
    logic          pop;

    assign req_ready = rst_n && (count_q < DEPTH_C);
    // Writes to register 0 complete the handshake but are never queued.
    assign push      = req_valid && req_ready && (req_addr != 5'd0) && !flush;
    assign pop       = (count_q != 4'd0) && !flush;

    assign A3    = a3_q;
    assign WD3   = wd3_q;
    assign WE3   = we3_q;
    assign count = count_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        a3_d    = a3_q;
        wd3_d   = wd3_q;
        we3_d   = 1'b1;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
                a3_d   = addr_q[head_q];
                wd3_d  = data_q[head_q];
                we3_d  = 1'b0;
            end
            count_d = count_q + {3'b000, push} - {3'b000, pop};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            a3_q    <= '0;
            wd3_q   <= '0;
            we3_q   <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            a3_q    <= a3_d;
            wd3_q   <= wd3_d;
            we3_q   <= we3_d;
        end
    end

    // NOTE: the entry storage is not reset; count_q alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= req_addr;
            data_q[tail_q] <= req_data;
        end
    end

    // Scan oldest to newest so the youngest matching entry overrides older ones.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        byp_hit1  = 1'b0;
        byp_hit2  = 1'b0;
        byp_data1 = '0;
        byp_data2 = '0;
        busy      = '0;
        if (!we3_q) begin
            busy[a3_q] = 1'b1;
            if (a3_q == rd_addr1) begin
                byp_hit1  = 1'b1;
                byp_data1 = wd3_q;
            end
            if (a3_q == rd_addr2) begin
                byp_hit2  = 1'b1;
                byp_data2 = wd3_q;
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (k < int'(count_q)) begin
                busy[addr_q[idx]] = 1'b1;
                if (addr_q[idx] == rd_addr1) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = data_q[idx];
                end
                if (addr_q[idx] == rd_addr2) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = data_q[idx];
                end
            end
        end
        if (rd_addr1 == 5'd0) begin
            byp_hit1  = 1'b0;
            byp_data1 = '0;
        end
        if (rd_addr2 == 5'd0) begin
            byp_hit2  = 1'b0;
            byp_data2 = '0;
        end
        busy[0] = 1'b0;
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: a table of single-cycle vectors followed
// by a streaming sequence that checks drain order, latency and pointer wrap.
module tb_wb_write_queue;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_addr;
    logic [31:0] req_data;
    logic        flush;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        WE3;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic        byp_hit1;
    logic        byp_hit2;
    logic [31:0] byp_data1;
    logic [31:0] byp_data2;
    logic [31:0] busy;
    logic [3:0]  count;

    int checks   = 0;
    int failures = 0;

    wb_write_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .flush     (flush),
        .A3        (A3),
        .WD3       (WD3),
        .WE3       (WE3),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .byp_hit1  (byp_hit1),
        .byp_hit2  (byp_hit2),
        .byp_data1 (byp_data1),
        .byp_data2 (byp_data2),
        .busy      (busy),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        valid;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        flush;
        logic [4:0]  rd1;
        logic [4:0]  rd2;
        logic        exp_ready;
        logic [3:0]  exp_count;
        logic        exp_we3;
        logic [4:0]  exp_a3;
        logic [31:0] exp_wd3;
        logic        exp_hit1;
        logic [31:0] exp_d1;
        logic        exp_hit2;
        logic [31:0] exp_d2;
        logic [31:0] exp_busy;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    vec_t vecs[$];

    initial begin
        int nwr;
        int last_c;
        int first_c;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        flush     = 1'b0;
        rd_addr1  = '0;
        rd_addr2  = '0;

        //          rst v  addr   data          fl rd1    rd2    rdy cnt   we a3     wd3           h1 d1            h2 d2            busy
        vecs.push_back('{0, 1, 5'd3,  32'h0000_0001, 0, 5'd3,  5'd0,  0, 4'd0, 1, 5'd0,  32'h0,         0, 32'h0,         0, 32'h0,         32'h0});
        vecs.push_back('{1, 0, 5'd0,  32'h0,         0, 5'd5,  5'd0,  1, 4'd0, 1, 5'd0,  32'h0,         0, 32'h0,         0, 32'h0,         32'h0});
        vecs.push_back('{1, 1, 5'd5,  32'hDEAD_BEEF, 0, 5'd5,  5'd5,  1, 4'd1, 1, 5'd0,  32'h0,         1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 32'h0000_0020});
        vecs.push_back('{1, 0, 5'd0,  32'h0,         0, 5'd5,  5'd0,  1, 4'd0, 0, 5'd5,  32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 0, 32'h0,         32'h0000_0020});
        vecs.push_back('{1, 0, 5'd0,  32'h0,         0, 5'd5,  5'd0,  1, 4'd0, 1, 5'd5,  32'hDEAD_BEEF, 0, 32'h0,         0, 32'h0,         32'h0});
        vecs.push_back('{1, 1, 5'd0,  32'hFFFF_FFFF, 0, 5'd0,  5'd5,  1, 4'd0, 1, 5'd5,  32'hDEAD_BEEF, 0, 32'h0,         0, 32'h0,         32'h0});
        vecs.push_back('{1, 1, 5'd7,  32'h0000_0011, 0, 5'd7,  5'd0,  1, 4'd1, 1, 5'd5,  32'hDEAD_BEEF, 1, 32'h0000_0011, 0, 32'h0,         32'h0000_0080});
        vecs.push_back('{1, 1, 5'd7,  32'h0000_0022, 0, 5'd7,  5'd0,  1, 4'd1, 0, 5'd7,  32'h0000_0011, 1, 32'h0000_0022, 0, 32'h0,         32'h0000_0080});
        vecs.push_back('{1, 0, 5'd0,  32'h0,         0, 5'd7,  5'd0,  1, 4'd0, 0, 5'd7,  32'h0000_0022, 1, 32'h0000_0022, 0, 32'h0,         32'h0000_0080});
        vecs.push_back('{1, 0, 5'd0,  32'h0,         0, 5'd7,  5'd0,  1, 4'd0, 1, 5'd7,  32'h0000_0022, 0, 32'h0,         0, 32'h0,         32'h0});
        vecs.push_back('{1, 1, 5'd9,  32'h0000_0099, 0, 5'd9,  5'd10, 1, 4'd1, 1, 5'd7,  32'h0000_0022, 1, 32'h0000_0099, 0, 32'h0,         32'h0000_0200});
        vecs.push_back('{1, 1, 5'd10, 32'h0000_00AA, 0, 5'd9,  5'd10, 1, 4'd1, 0, 5'd9,  32'h0000_0099, 1, 32'h0000_0099, 1, 32'h0000_00AA, 32'h0000_0600});
        vecs.push_back('{1, 1, 5'd11, 32'h0000_00BB, 1, 5'd11, 5'd10, 1, 4'd0, 1, 5'd9,  32'h0000_0099, 0, 32'h0,         0, 32'h0,         32'h0});
        vecs.push_back('{1, 0, 5'd0,  32'h0,         0, 5'd11, 5'd0,  1, 4'd0, 1, 5'd9,  32'h0000_0099, 0, 32'h0,         0, 32'h0,         32'h0});
        vecs.push_back('{1, 1, 5'd12, 32'h0000_00C1, 0, 5'd12, 5'd13, 1, 4'd1, 1, 5'd9,  32'h0000_0099, 1, 32'h0000_00C1, 0, 32'h0,         32'h0000_1000});
        vecs.push_back('{1, 1, 5'd13, 32'h0000_00C2, 0, 5'd12, 5'd13, 1, 4'd1, 0, 5'd12, 32'h0000_00C1, 1, 32'h0000_00C1, 1, 32'h0000_00C2, 32'h0000_3000});
        vecs.push_back('{0, 0, 5'd0,  32'h0,         0, 5'd12, 5'd13, 0, 4'd0, 1, 5'd0,  32'h0,         0, 32'h0,         0, 32'h0,         32'h0});
        vecs.push_back('{1, 0, 5'd0,  32'h0,         0, 5'd12, 5'd13, 1, 4'd0, 1, 5'd0,  32'h0,         0, 32'h0,         0, 32'h0,         32'h0});
        vecs.push_back('{1, 0, 5'd0,  32'h0,         0, 5'd12, 5'd13, 1, 4'd0, 1, 5'd0,  32'h0,         0, 32'h0,         0, 32'h0,         32'h0});

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            rst_n     = vecs[i].rst_n;
            req_valid = vecs[i].valid;
            req_addr  = vecs[i].addr;
            req_data  = vecs[i].data;
            flush     = vecs[i].flush;
            rd_addr1  = vecs[i].rd1;
            rd_addr2  = vecs[i].rd2;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d.req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            check($sformatf("v%0d.count", i),     32'(count),     32'(vecs[i].exp_count));
            check($sformatf("v%0d.WE3", i),       32'(WE3),       32'(vecs[i].exp_we3));
            check($sformatf("v%0d.A3", i),        32'(A3),        32'(vecs[i].exp_a3));
            check($sformatf("v%0d.WD3", i),       WD3,            vecs[i].exp_wd3);
            check($sformatf("v%0d.byp_hit1", i),  32'(byp_hit1),  32'(vecs[i].exp_hit1));
            check($sformatf("v%0d.byp_data1", i), byp_data1,      vecs[i].exp_d1);
            check($sformatf("v%0d.byp_hit2", i),  32'(byp_hit2),  32'(vecs[i].exp_hit2));
            check($sformatf("v%0d.byp_data2", i), byp_data2,      vecs[i].exp_d2);
            check($sformatf("v%0d.busy", i),      busy,           vecs[i].exp_busy);
        end

        // Streaming pushes: six back-to-back requests wrap the 4-entry pointers
        // and must drain as consecutive single-cycle WE3 pulses in order.
        rd_addr1 = '0;
        rd_addr2 = '0;
        nwr      = 0;
        last_c   = -1;
        first_c  = -1;
        for (int c = 0; c < 20; c++) begin
            if (c < 6) begin
                req_valid = 1'b1;
                req_addr  = 5'(c + 1);
                req_data  = 32'h100 + 32'(c + 1);
            end else begin
                req_valid = 1'b0;
                req_addr  = '0;
                req_data  = '0;
            end
            @(posedge clk);
            @(negedge clk);
            if (c < 6) begin
                check($sformatf("stream%0d.req_ready", c), 32'(req_ready), 32'd1);
            end
            if (WE3 == 1'b0) begin
                check($sformatf("stream.wr%0d.A3", nwr),  32'(A3), 32'(nwr + 1));
                check($sformatf("stream.wr%0d.WD3", nwr), WD3,     32'h100 + 32'(nwr + 1));
                if (first_c < 0) begin
                    first_c = c;
                end else begin
                    check($sformatf("stream.wr%0d.consecutive", nwr), 32'(c), 32'(last_c + 1));
                end
                last_c = c;
                nwr++;
            end
        end
        check("stream.first_write_cycle", 32'(first_c), 32'd1);
        check("stream.write_count", 32'(nwr), 32'd6);
        check("stream.final_count", 32'(count), 32'd0);
        check("stream.final_WE3", 32'(WE3), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
